serial_adder_seq: RTL

//  Multi-cycle sequencer that adds two WIDTH-bit operands plus carry-in on the existing
//  2-bit ripple `adder` (lhs, rhs, cin -> out, cout), one 2-bit digit per clock, LSB first.

---
 rtl/serial_adder_seq_pkg.sv | 17 +
 rtl/serial_adder_seq_if.sv | 24 ++
 rtl/serial_adder_seq_adder.sv | 15 +
 rtl/serial_adder_seq.sv | 98 +++++++++
 4 files changed

// File: rtl/serial_adder_seq_pkg.sv
// rtl/serial_adder_seq_pkg.sv - shared types and constants for the serial adder sequencer
package serial_adder_seq_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Digit counter width; at least one bit even when there is a single digit.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_adder_seq_if.sv
// rtl/serial_adder_seq_if.sv - operand/result valid-ready bus of the serial adder sequencer
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_lhs;
    logic [WIDTH-1:0] in_rhs;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_valid, in_lhs, in_rhs, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_lhs, in_rhs, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/serial_adder_seq_adder.sv
// rtl/serial_adder_seq_adder.sv - combinational 2-bit digit adder with carry
module adder
    import serial_adder_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] lhs,
    input  logic [DIGIT_W-1:0] rhs,
    input  logic               cin,
    output logic [DIGIT_W-1:0] out,
    output logic               cout
);

    // Zero-extend to DIGIT_W+1 so the carry falls out of the top bit.
    assign {cout, out} = {1'b0, lhs} + {1'b0, rhs} + {{DIGIT_W{1'b0}}, cin};

endmodule

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - adds two WIDTH-bit operands one 2-bit digit per clock, LSB first
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    serial_adder_seq_if.slave bus
);

    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CNTW = cnt_width(NDIG);

    if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
        $error("serial_adder_seq: WIDTH must be even and >= 2");
    end

    state_t            state_q;
    state_t            state_d;
    logic [CNTW-1:0]   cnt_q;
    logic [WIDTH-1:0]  lhs_sr;
    logic [WIDTH-1:0]  rhs_sr;
    logic              carry_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic [DIGIT_W-1:0] dig_sum;
    logic              dig_cout;
    logic              last_dig;

    adder u_adder (
        .lhs  (lhs_sr[DIGIT_W-1:0]),
        .rhs  (rhs_sr[DIGIT_W-1:0]),
        .cin  (carry_q),
        .out  (dig_sum),
        .cout (dig_cout)
    );

    assign last_dig      = (cnt_q == CNTW'(NDIG - 1));
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;

    // Next-state: accept in IDLE, walk the digits in RUN, wait for drain in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_RUN;
            S_RUN:   if (last_dig)     state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath: capture operands, then retire one digit of the sum per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            lhs_sr  <= '0;
            rhs_sr  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        lhs_sr  <= bus.in_lhs;
                        rhs_sr  <= bus.in_rhs;
                        carry_q <= bus.in_cin;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    sum_q[{cnt_q, 1'b0} +: DIGIT_W] <= dig_sum;
                    carry_q <= dig_cout;
                    lhs_sr  <= lhs_sr >> DIGIT_W;
                    rhs_sr  <= rhs_sr >> DIGIT_W;
                    if (last_dig) begin
                        cout_q <= dig_cout;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q  <= cnt_q + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
